// File: rtl/td4_pkg.sv
// Shared TD4 datapath constants: operand select codes and default data width.
package td4_pkg;

   localparam int unsigned TD4_WIDTH = 4;

   localparam logic [1:0] SEL_REG_A   = 2'b00;
   localparam logic [1:0] SEL_REG_B   = 2'b01;
   localparam logic [1:0] SEL_IN_PORT = 2'b10;
   localparam logic [1:0] SEL_ZERO    = 2'b11;

endpackage : td4_pkg

// File: rtl/data_selector_sw_sync.sv
// Multi-bit flop-chain synchronizer for the asynchronous switch input port.
module sw_sync
   import td4_pkg::*;
#(
   parameter int unsigned WIDTH       = TD4_WIDTH,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

   // Shift the raw input into stage 0; each later stage takes its predecessor.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Chain register; reset clears every stage so the port reads zero until refilled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule : sw_sync

// File: rtl/data_selector.sv
// TD4 ALU operand source mux: picks A, B, synchronized switch port or zero, registered.
module data_selector
   import td4_pkg::*;
#(
   parameter int unsigned WIDTH       = TD4_WIDTH,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             I_CLK,
   input  logic             I_RST,
   input  logic [WIDTH-1:0] IN_A,
   input  logic [WIDTH-1:0] IN_B,
   input  logic [WIDTH-1:0] IN_SW,
   input  logic             SEL_A,
   input  logic             SEL_B,
   output logic [WIDTH-1:0] OUT_Y
);

   logic [WIDTH-1:0] sw_s;
   logic [1:0]       sel_c;
   logic [WIDTH-1:0] out_y_d;
   logic [WIDTH-1:0] out_y_q;

   sw_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sw_sync (
      .clk_i (I_CLK),
      .rst_i (I_RST),
      .d_i   (IN_SW),
      .q_o   (sw_s)
   );

   assign sel_c = {SEL_B, SEL_A};

   // 4:1 operand mux; any code outside A/B/port (including X) falls to zero.
   always_comb begin
      out_y_d = '0;
      case (sel_c)
         SEL_REG_A:   out_y_d = IN_A;
         SEL_REG_B:   out_y_d = IN_B;
         SEL_IN_PORT: out_y_d = sw_s;
         default:     out_y_d = '0;
      endcase
   end

   // Output register loads every cycle; no hold path.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         out_y_q <= '0;
      end else begin
         out_y_q <= out_y_d;
      end
   end

   assign OUT_Y = out_y_q;

endmodule : data_selector

// File: tb/tb_data_selector.sv
// Scoreboard bench for data_selector: stimulus pushes expected OUT_Y, monitor pops and compares.
module tb_data_selector;

   localparam int unsigned W = 4;
   localparam int unsigned S = 2;

   typedef struct {
      logic [W-1:0] exp;
      string        tag;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] in_sw;
   logic         sel_a;
   logic         sel_b;
   logic [W-1:0] out_y;

   exp_t         sb[$];
   // Per-edge history of what the DUT sampled, newest first.
   logic [W-1:0] sw_hist[$];
   bit           rst_hist[$];

   int checks = 0;
   int errors = 0;
   bit done   = 0;

   data_selector #(
      .WIDTH       (W),
      .SYNC_STAGES (S)
   ) dut (
      .I_CLK (clk),
      .I_RST (rst),
      .IN_A  (in_a),
      .IN_B  (in_b),
      .IN_SW (in_sw),
      .SEL_A (sel_a),
      .SEL_B (sel_b),
      .OUT_Y (out_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the switch value seen by the mux at edge N is the one sampled S edges
   // earlier, unless a reset landed on any of the S edges in between.
   function automatic logic [W-1:0] model_sw();
      logic [W-1:0] v;
      v = sw_hist[S-1];
      for (int i = 0; i < int'(S); i++) begin
         if (rst_hist[i]) v = '0;
      end
      return v;
   endfunction

   task automatic drive(input bit r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] sw, input int sel, input string tag);
      exp_t e;
      @(negedge clk);
      rst   = r;
      in_a  = a;
      in_b  = b;
      in_sw = sw;
      sel_a = sel[0];
      sel_b = sel[1];
      if (r) e.exp = '0;
      else if (sel == 0) e.exp = a;
      else if (sel == 1) e.exp = b;
      else if (sel == 2) e.exp = model_sw();
      else e.exp = '0;
      e.tag = tag;
      sb.push_back(e);
      sw_hist.push_front(sw);
      rst_hist.push_front(r);
      if (sw_hist.size() > S + 1) begin
         void'(sw_hist.pop_back());
         void'(rst_hist.pop_back());
      end
   endtask

   // Monitor: OUT_Y is always valid, so compare after every edge that has an expectation.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (out_y !== e.exp) begin
            errors++;
            $display("FAIL %s: OUT_Y=%h expected %h at %0t", e.tag, out_y, e.exp, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_a = '0; in_b = '0; in_sw = '0; sel_a = 1'b0; sel_b = 1'b0;
      for (int i = 0; i < int'(S); i++) begin
         sw_hist.push_front('0);
         rst_hist.push_front(1'b1);
      end

      // Reset holds OUT_Y at zero, first edge after release loads A.
      drive(1, 4'h5, 4'h0, 4'h0, 0, "reset");
      drive(1, 4'h5, 4'h0, 4'h0, 0, "reset");
      drive(0, 4'h5, 4'h0, 4'h0, 0, "reset_release");

      // Register selects.
      drive(0, 4'h3, 4'hC, 4'h0, 0, "sel_a");
      drive(0, 4'h3, 4'hC, 4'h0, 1, "sel_b");
      drive(0, 4'hA, 4'h7, 4'h0, 0, "sel_a_change");

      // Switch port latency: 0 for S edges, then 9.
      drive(0, 4'h3, 4'hC, 4'h0, 2, "port_pre");
      drive(0, 4'h3, 4'hC, 4'h0, 2, "port_pre");
      for (int i = 0; i < 4; i++) drive(0, 4'h3, 4'hC, 4'h9, 2, "port_latency");

      // Zero select with everything at F.
      for (int i = 0; i < 4; i++) drive(0, 4'hF, 4'hF, 4'hF, 3, "sel_zero");

      // Mid-run reset on the port path.
      for (int i = 0; i < 4; i++) drive(0, 4'h1, 4'h2, 4'h6, 2, "port_settle");
      drive(1, 4'h1, 4'h2, 4'h6, 2, "mid_reset");
      for (int i = 0; i < 5; i++) drive(0, 4'h1, 4'h2, 4'h6, 2, "post_reset");

      // Sweep of all select codes with random operands.
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 16; i++) begin
            drive(0, W'($urandom), W'($urandom), W'($urandom), s, "sweep");
         end
      end

      // Random traffic with occasional resets and select changes every cycle.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 19) == 0), W'($urandom), W'($urandom), W'($urandom),
               int'($urandom_range(0, 3)), "random");
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_data_selector

// File: doc/data_selector.md
# data_selector

The data selector is the ALU-operand source multiplexer of the TD4 4-bit CPU datapath. It picks one of four operands and feeds it to the adder: register A, register B, the switch input port, or constant zero. The 2-bit select comes from the instruction decoder (SEL_A, SEL_B). The result is registered, and the asynchronous switch input is synchronized before use.

## Interface
Module name: `data_selector`. One clock; reset is synchronous and active-high.

Parameters:
- WIDTH, default 4: data width of all operand and result buses.
- SYNC_STAGES, default 2: flop stages in the IN_SW synchronizer; legal range 1–4.

Ports:
- I_CLK, input, 1: system clock; all state updates on its rising edge.
- I_RST, input, 1: synchronous active-high reset.
- IN_A, input, WIDTH: register A contents. Synchronous to I_CLK.
- IN_B, input, WIDTH: register B contents. Synchronous to I_CLK.
- IN_SW, input, WIDTH: switch input port. Asynchronous to I_CLK.
- SEL_A, input, 1: select bit 0 (LSB), from the decoder.
- SEL_B, input, 1: select bit 1 (MSB), from the decoder.
- OUT_Y, output, WIDTH: registered selected operand, driven to the adder.

## Operation
- Select code is sel = {SEL_B, SEL_A}:
  - 2'b00 selects IN_A.
  - 2'b01 selects IN_B.
  - 2'b10 selects the synchronized IN_SW value, sw_s.
  - 2'b11 selects constant zero.
- sw_s is the output of a SYNC_STAGES-deep flop chain clocked by I_CLK.
- OUT_Y is updated every clock with the selected value.
- No enable or hold input exists; the register loads every cycle.
- No arithmetic is performed. Values pass through unchanged at width WIDTH; no truncation or extension.
- X or Z on SEL_A/SEL_B is not a legal input. The implementation treats any non-00/01/10 code as zero (default branch).

## Timing
- Reset: when I_RST=1 at a rising edge:
  - OUT_Y is 0 after that edge.
  - All synchronizer stages are 0.
- Reset mid-operation: takes effect at the next edge regardless of select. The pipeline restarts from zero, so after release sw_s reads 0 until SYNC_STAGES edges have passed.
- IN_A / IN_B / select path latency: 1 cycle. Values present before edge N appear on OUT_Y after edge N.
- IN_SW path latency: SYNC_STAGES+1 cycles. A switch change stable before edge N is visible on OUT_Y after edge N+SYNC_STAGES, provided sel=2'b10 before that edge.
- Select change and data change in the same cycle: OUT_Y after the edge reflects the new select applied to the new data.
- The synchronizer runs continuously, independent of select. Switching to sel=2'b10 yields the current sw_s with 1-cycle latency.
- No handshake; OUT_Y is always valid outside reset.

## Structure
- Shared package `td4_pkg`:
  - Select-code constants: SEL_REG_A=2'b00, SEL_REG_B=2'b01, SEL_IN_PORT=2'b10, SEL_ZERO=2'b11.
  - Default data width constant TD4_WIDTH=4.
- One sub-module, `sw_sync`:
  - Parameterized WIDTH and SYNC_STAGES multi-bit flop chain.
  - Synchronous reset to 0.
  - Instantiated once for IN_SW.
- Top level contains the combinational 4:1 mux (case on the select code) plus the OUT_Y register.

## Test plan
- Reset: IN_A=4'h5, sel=00, I_RST=1 for 2 cycles -> OUT_Y=0. First edge after release -> OUT_Y=4'h5.
- Register select: IN_A=4'h3, IN_B=4'hC. Sel 00 -> OUT_Y=3 after 1 edge; sel 01 -> OUT_Y=C after 1 edge.
- Input port latency: sel=10 held, IN_SW changes 0->4'h9 between edges, SYNC_STAGES=2 -> OUT_Y is 0 for 2 edges, then 9 after the 3rd edge.
- Zero select: IN_A=IN_B=IN_SW=4'hF settled, sel=11 -> OUT_Y=0 after 1 edge.
- Mid-run reset: sel=10, IN_SW=4'h6 settled, OUT_Y=6. Assert I_RST one cycle -> OUT_Y=0, then OUT_Y stays 0 for SYNC_STAGES edges after release before returning to 6.
- Exhaustive sweep: all 4 select codes × 16 random (A, B, SW) triples -> OUT_Y matches the select-code mapping with the stated latencies.
